bbc_bus_resp: RTL and testbench
===============================

# bbc_bus_resp

BBC-side bus responder for the 1MHz BBC host bus driven by the CPU-board CPLD. It oversamples `bbc_phi2` on the fast local clock, decodes each bus cycle from the full BBC address, `bbc_rnw` and data, and answers SHEILA-page (FE00-FEFF) accesses. It holds a copy of the paged-ROM select register, logs every SHEILA write into a small FIFO for a local consumer, and exposes a mailbox status register. It serves as the bus-model target in system benches and as the basis of a host-side debug peripheral.

## Interface
- `ROMSEL_ADR`, 16'hFE30: paged ROM select register address.
- `MBOX_ADR`, 16'hFE38: mailbox status register address.
- `FIFO_DEPTH`, 4: write-log depth; power of two, 2..8.
- `hsclk` in 1: the only clock; all flops use its rising edge.
- `resetb` in 1: reset is synchronous and active-low.
- `bbc_phi2` in 1: asynchronous BBC phase-2 clock, sampled as data.
- `bbc_adr` in 16: full BBC address.
- `bbc_rnw` in 1: 1 means read, 0 means write.
- `bbc_data_in` in 8: BBC data bus input.
- `bbc_data_out` out 8: read data.
- `bbc_data_oe` out 1: drive enable for `bbc_data_out`.
- `romsel_q` out 4: copy of the ROM select register, bits [3:0].
- `wlog_valid` out 1: the write-log head entry is valid.
- `wlog_adr` out 8: low address byte of the head entry.
- `wlog_data` out 8: data of the head entry.
- `wlog_ready` in 1: pops the head entry when it is high in the same cycle as `wlog_valid`.
- `dummy_cnt` out 16: count of page-80 reads.

## Operation
- **Synchronizer and edge detect**
  - Two-flop synchronizer `s1`, `s2` on `bbc_phi2`, plus a registered copy `s3`.
  - Rise: `s2 & !s3`. Fall: `!s2 & s3`.
- **FSM states:** IDLE, RD, WR, SKIP.
  - IDLE, on rise, latches `bbc_adr` and `bbc_rnw`. It goes to:
    - RD for a read of `ROMSEL_ADR` or `MBOX_ADR`;
    - WR for any write to FE00-FEFF;
    - SKIP otherwise.
  - RD, WR and SKIP all return to IDLE on fall.
- **Read data**
  - `bbc_data_oe` is 1 only while in RD.
  - ROMSEL read returns {4'b0, `romsel_q`}.
  - MBOX read returns {ovf, 3'b0, count[3:0]}.
  - The ovf bit clears on the fall that ends an MBOX read, unless an overflow occurs in that same cycle; the overflow wins.
- **Write data**
  - Register `wd` loads `bbc_data_in` every cycle while `s1` is high.
  - On fall in WR, `wd` is committed:
    - It is pushed to the FIFO as {adr[7:0], `wd`}.
    - If the address equals `ROMSEL_ADR`, `romsel_q` takes `wd[3:0]`.
- **FIFO**
  - Full with a push and no pop: the push is dropped and ovf is set (sticky).
  - Full with a push and a pop in the same cycle: both are accepted; count is unchanged and ovf is not set.
  - Empty: `wlog_valid` = 0, and `wlog_ready` is ignored.
  - The head entry is registered; a push into an empty FIFO shows `wlog_valid` one cycle after the commit.
- **Environment requirements**
  - `hsclk` is at least 8x the `bbc_phi2` frequency.
  - `bbc_adr` and `bbc_rnw` are stable from at least 3 hsclk cycles before the phi2 rise.
  - Write data is held at least 2 hsclk cycles after the phi2 fall.

## Timing
- **Reset** (while `resetb` = 0 at a clock edge):
  - State goes to IDLE.
  - `bbc_data_oe` = 0, `bbc_data_out` = 8'h00, `romsel_q` = 0.
  - FIFO is emptied, ovf = 0, `wlog_valid` = 0, `wlog_adr`/`wlog_data` = 0, `dummy_cnt` = 0.
  - Synchronizer flops are cleared.
- **Reset during a bus cycle:** the cycle is abandoned; a new cycle starts only at the next detected rise.
- **Output enable:** `bbc_data_oe` asserts 3 hsclk after the raw phi2 rise (2 synchronizer stages plus the state register). It deasserts 3 hsclk after the raw fall.
- **Read data** is valid on the same cycle that `bbc_data_oe` asserts and is held constant through RD.
- **Write commit** happens at fall detection plus 1 cycle: `romsel_q` updates and the FIFO count increments.

## Configuration
- `BBC_RESP_DUMMY_CNT_EN` defined:
  - `dummy_cnt` increments by 1 on each IDLE-to-SKIP transition whose latched address high byte is 8'h80 with `bbc_rnw` = 1.
  - These are the CPLD's forced dummy reads, plus genuine page-80 reads.
  - The counter wraps from 16'hFFFF to 0.
- Undefined: `dummy_cnt` is tied to 16'h0000 and no counter flops are built.

## Structure
- Package `bbc_bus_pkg` holds:
  - the FSM state enum;
  - `BBC_SHEILA_PAGE` (8'hFE);
  - `BBC_DUMMY_PAGE` (8'h80);
  - the default register addresses;
  - the MBOX bit positions.
- Sub-module `bbc_resp_fifo` is a synchronous FIFO with push/pop, count, full/empty and registered head; its parameters are width 16 and `FIFO_DEPTH`.

## Test plan
- Reset: hold `resetb` low for 4 cycles mid-read. Expect `bbc_data_oe` = 0 next edge, all outputs at reset values, and no commit.
- ROMSEL: write 8'h0F to FE30. Expect `romsel_q` = 4'hF; a read of FE30 drives 8'h0F with oe for exactly the RD window; one log entry {8'h30, 8'h0F}.
- Overflow: with `wlog_ready` = 0, make 5 writes to FE40..FE44. Expect count 4, the 5th write dropped, MBOX read returns 8'h84, and a second MBOX read returns 8'h04.
- Simultaneous push and pop: with the FIFO full, pulse `wlog_ready` on the commit cycle of a write. Expect count to stay 4, ovf = 0, and the new entry at the tail.
- Non-decoded accesses: a read of FE31 and a write to 3000 give no oe, no log entry and no `romsel_q` change.
- Dummy count: with `BBC_RESP_DUMMY_CNT_EN`, 3 reads at 8000 give `dummy_cnt` = 3; a write to 8000 does not increment; preloaded 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/bbc_bus_pkg.sv
// bbc_bus_pkg: shared FSM states, page constants, default register addresses and mailbox layout.
package bbc_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_SKIP} bbc_state_t;
  localparam logic [7:0] BBC_SHEILA_PAGE = 8'hFE;
  localparam logic [7:0] BBC_DUMMY_PAGE = 8'h80;
  localparam logic [15:0] BBC_ROMSEL_ADR = 16'hFE30;
  localparam logic [15:0] BBC_MBOX_ADR = 16'hFE38;
  localparam int BBC_FIFO_DEPTH = 4;
  localparam int MBOX_OVF_BIT = 7;
  localparam int MBOX_CNT_LSB = 0;
endpackage

// File: rtl/bbc_resp_fifo.sv
// bbc_resp_fifo: synchronous FIFO with registered head; a push into an empty FIFO shows valid one cycle later.
module bbc_resp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             hsclk,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [3:0]       count,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic pop, accept, empty;
  assign full = count == FULL_CNT;
  assign empty = count == 4'd0;
  assign pop = ready & head_valid;
  assign accept = push & (~full | pop);
  assign rd_nxt = rd_ptr + 1'b1;
  always_ff @(posedge hsclk)
    if (accept) mem[wr_ptr] <= din;
  // On a pop the head jumps straight to the next stored entry so it is never seen twice.
  always_ff @(posedge hsclk)
    if (!resetb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= 4'd0;
      head_valid <= 1'b0;
      head <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_nxt;
      count <= count + 4'(accept) - 4'(pop);
      head_valid <= pop ? count > 4'd1 : !empty;
      if (pop || !empty) head <= pop ? mem[rd_nxt] : mem[rd_ptr];
    end
endmodule

// File: rtl/bbc_bus_resp.sv
// bbc_bus_resp: BBC 1MHz bus SHEILA responder with ROM select copy, write log and mailbox.
// Define BBC_RESP_DUMMY_CNT_EN to build the page-80 read counter on dummy_cnt.
module bbc_bus_resp
  import bbc_bus_pkg::*;
#(
  parameter logic [15:0] ROMSEL_ADR = BBC_ROMSEL_ADR,
  parameter logic [15:0] MBOX_ADR = BBC_MBOX_ADR,
  parameter int FIFO_DEPTH = BBC_FIFO_DEPTH
) (
  input  logic        hsclk,
  input  logic        resetb,
  input  logic        bbc_phi2,
  input  logic [15:0] bbc_adr,
  input  logic        bbc_rnw,
  input  logic [7:0]  bbc_data_in,
  output logic [7:0]  bbc_data_out,
  output logic        bbc_data_oe,
  output logic [3:0]  romsel_q,
  output logic        wlog_valid,
  output logic [7:0]  wlog_adr,
  output logic [7:0]  wlog_data,
  input  logic        wlog_ready,
  output logic [15:0] dummy_cnt
);
  bbc_state_t state;
  logic s1, s2, s3, rise, fall, push, overflow, full, mbox_clr, rd_hit, wr_hit, ovf;
  logic [15:0] adr;
  logic [7:0] wd, mbox;
  logic [3:0] count;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign push = state == ST_WR && fall;
  assign overflow = push & full & ~(wlog_ready & wlog_valid);
  assign mbox_clr = state == ST_RD && fall && adr == MBOX_ADR;
  assign rd_hit = bbc_rnw && (bbc_adr == ROMSEL_ADR || bbc_adr == MBOX_ADR);
  assign wr_hit = !bbc_rnw && bbc_adr[15:8] == BBC_SHEILA_PAGE;
  always_comb begin
    mbox = 8'h00;
    mbox[MBOX_OVF_BIT] = ovf;
    mbox[MBOX_CNT_LSB +: 4] = count;
  end
  always_ff @(posedge hsclk)
    if (!resetb) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      state <= ST_IDLE;
      adr <= 16'h0000;
      wd <= 8'h00;
      ovf <= 1'b0;
      romsel_q <= 4'h0;
      bbc_data_oe <= 1'b0;
      bbc_data_out <= 8'h00;
    end else begin
      s1 <= bbc_phi2;
      s2 <= s1;
      s3 <= s2;
      if (s1) wd <= bbc_data_in;
      ovf <= overflow | (ovf & ~mbox_clr);
      case (state)
        ST_IDLE:
          if (rise) begin
            adr <= bbc_adr;
            state <= rd_hit ? ST_RD : wr_hit ? ST_WR : ST_SKIP;
            bbc_data_oe <= rd_hit;
            if (rd_hit) bbc_data_out <= bbc_adr == ROMSEL_ADR ? {4'h0, romsel_q} : mbox;
          end
        default:
          if (fall) begin
            state <= ST_IDLE;
            bbc_data_oe <= 1'b0;
            if (state == ST_WR && adr == ROMSEL_ADR) romsel_q <= wd[3:0];
          end
      endcase
    end
  bbc_resp_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .hsclk      (hsclk),
    .resetb     (resetb),
    .push       (push),
    .din        ({adr[7:0], wd}),
    .ready      (wlog_ready),
    .head       ({wlog_adr, wlog_data}),
    .head_valid (wlog_valid),
    .count      (count),
    .full       (full)
  );
`ifdef BBC_RESP_DUMMY_CNT_EN
  logic [15:0] dcnt;
  always_ff @(posedge hsclk)
    if (!resetb) dcnt <= 16'h0000;
    else if (state == ST_IDLE && rise && bbc_rnw && bbc_adr[15:8] == BBC_DUMMY_PAGE) dcnt <= dcnt + 1'b1;
  assign dummy_cnt = dcnt;
`else
  assign dummy_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_bbc_bus_resp.sv
// tb_bbc_bus_resp: randomized and directed bus cycles checked every clock against a queue-based model.
module tb_bbc_bus_resp;
  localparam logic [15:0] ROMSEL = 16'hFE30;
  localparam logic [15:0] MBOX = 16'hFE38;
  localparam int DEPTH = 4;
  localparam int BIG = 1 << 30;
`ifdef BBC_RESP_DUMMY_CNT_EN
  localparam logic [15:0] EXP3 = 16'd3;
`else
  localparam logic [15:0] EXP3 = 16'd0;
`endif
  typedef struct {logic [7:0] a; logic [7:0] d; int pc;} ent_t;
  logic hsclk = 1'b0;
  logic resetb, bbc_phi2, bbc_rnw, bbc_data_oe, wlog_valid, wlog_ready;
  logic [15:0] bbc_adr, dummy_cnt;
  logic [7:0] bbc_data_in, bbc_data_out, wlog_adr, wlog_data;
  logic [3:0] romsel_q;
  ent_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, b_rise = 0, b_fall = BIG, oe_cnt = 0, rdy_mode = 0;
  bit b_live = 0, m_ovf = 0;
  logic [15:0] b_adr = 16'h0, m_dcnt = 16'h0;
  logic b_rnw = 1'b1;
  logic [7:0] b_wd = 8'h0, exp_data = 8'h0, last_rd = 8'h0;
  logic [3:0] m_romsel = 4'h0;

  bbc_bus_resp dut (
    .hsclk(hsclk), .resetb(resetb), .bbc_phi2(bbc_phi2), .bbc_adr(bbc_adr), .bbc_rnw(bbc_rnw),
    .bbc_data_in(bbc_data_in), .bbc_data_out(bbc_data_out), .bbc_data_oe(bbc_data_oe),
    .romsel_q(romsel_q), .wlog_valid(wlog_valid), .wlog_adr(wlog_adr), .wlog_data(wlog_data),
    .wlog_ready(wlog_ready), .dummy_cnt(dummy_cnt)
  );

  always #5 hsclk = ~hsclk;

  function automatic bit is_rd(input logic [15:0] a, input logic r);
    return r && (a == ROMSEL || a == MBOX);
  endfunction
  function automatic bit is_wr(input logic [15:0] a, input logic r);
    return !r && a[15:8] == 8'hFE;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // Model: bus events are keyed to cycle numbers (rise/fall + 3 synchroniser/state delays).
  always @(posedge hsclk) begin
    bit pop, commit;
    pop = wlog_ready && q.size() > 0 && q[0].pc < cyc;
    cyc = cyc + 1;
    commit = 0;
    if (!resetb) begin
      q.delete();
      m_ovf = 0;
      m_romsel = 4'h0;
      m_dcnt = 16'h0;
      b_live = 0;
    end else begin
      if (b_live) begin
        if (is_rd(b_adr, b_rnw) && cyc == b_rise + 3)
          exp_data = b_adr == ROMSEL ? {4'h0, m_romsel} : {m_ovf, 3'b000, 4'(q.size())};
`ifdef BBC_RESP_DUMMY_CNT_EN
        if (b_rnw && b_adr[15:8] == 8'h80 && cyc == b_rise + 3) m_dcnt = m_dcnt + 16'd1;
`endif
        if (b_rnw && b_adr == MBOX && cyc == b_fall + 3) m_ovf = 0;
        commit = is_wr(b_adr, b_rnw) && cyc == b_fall + 3;
      end
      if (pop) void'(q.pop_front());
      if (commit) begin
        if (b_adr == ROMSEL) m_romsel = b_wd[3:0];
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back('{b_adr[7:0], b_wd, cyc});
      end
    end
  end

  always @(negedge hsclk) if (cyc > 0) begin
    bit eoe, ev;
    eoe = b_live && is_rd(b_adr, b_rnw) && cyc >= b_rise + 3 && cyc < b_fall + 3;
    ev = q.size() > 0 && q[0].pc < cyc;
    check("oe", 32'(bbc_data_oe), 32'(eoe));
    if (eoe) check("rdata", 32'(bbc_data_out), 32'(exp_data));
    if (bbc_data_oe) begin
      last_rd = bbc_data_out;
      oe_cnt++;
    end
    check("romsel", 32'(romsel_q), 32'(m_romsel));
    check("wvalid", 32'(wlog_valid), 32'(ev));
    if (ev) check("whead", {16'h0, wlog_adr, wlog_data}, {16'h0, q[0].a, q[0].d});
    check("dummy", 32'(dummy_cnt), 32'(m_dcnt));
  end

  initial forever begin
    @(posedge hsclk);
    #1;
    wlog_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'($urandom_range(0, 1)) :
                 rdy_mode == 3 ? 1'(cyc == b_fall + 2) : 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hsclk);
      #1;
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] d, input bit abort = 0);
    tick(1);
    oe_cnt = 0;
    bbc_adr = a;
    bbc_rnw = r;
    bbc_data_in = d;
    tick(3);
    bbc_phi2 = 1'b1;
    b_adr = a;
    b_rnw = r;
    b_wd = d;
    b_rise = cyc;
    b_fall = BIG;
    b_live = 1;
    if (abort) begin
      tick(4);
      resetb = 1'b0;
      tick(1);
      check("rst_oe", 32'(bbc_data_oe), 32'h0);
      bbc_phi2 = 1'b0;
      tick(3);
      resetb = 1'b1;
    end else begin
      tick(6);
      bbc_phi2 = 1'b0;
      b_fall = cyc;
      tick(2);
      bbc_data_in = 8'($urandom);
      tick(4);
    end
  endtask

  initial begin
    logic [15:0] a;
    resetb = 1'b0;
    bbc_phi2 = 1'b0;
    bbc_adr = 16'h0;
    bbc_rnw = 1'b1;
    bbc_data_in = 8'h0;
    wlog_ready = 1'b0;
    tick(4);
    resetb = 1'b1;
    check("rst_oe0", 32'(bbc_data_oe), 32'h0);
    check("rst_dout", 32'(bbc_data_out), 32'h00);
    check("rst_romsel", 32'(romsel_q), 32'h0);
    check("rst_valid", 32'(wlog_valid), 32'h0);
    check("rst_wadr", 32'(wlog_adr), 32'h0);
    check("rst_wdata", 32'(wlog_data), 32'h0);
    check("rst_dummy", 32'(dummy_cnt), 32'h0);
    bus(ROMSEL, 1'b0, 8'h0F);
    check("romsel_wr", 32'(romsel_q), 32'hF);
    check("log_valid", 32'(wlog_valid), 32'h1);
    check("log_entry", {16'h0, wlog_adr, wlog_data}, 32'h300F);
    bus(ROMSEL, 1'b1, 8'h00);
    check("romsel_rd", 32'(last_rd), 32'h0F);
    check("oe_window", 32'(oe_cnt), 32'd6);
    rdy_mode = 1;
    tick(6);
    rdy_mode = 0;
    tick(1);
    check("drained", 32'(wlog_valid), 32'h0);
    for (int i = 0; i < 5; i++) bus(16'hFE40 + 16'(i), 1'b0, 8'($urandom));
    bus(MBOX, 1'b1, 8'h00);
    check("mbox_ovf", 32'(last_rd), 32'h84);
    bus(MBOX, 1'b1, 8'h00);
    check("mbox_clr", 32'(last_rd), 32'h04);
    rdy_mode = 3;
    bus(16'hFE45, 1'b0, 8'h55);
    rdy_mode = 0;
    check("pp_head", 32'(wlog_adr), 32'h41);
    bus(MBOX, 1'b1, 8'h00);
    check("pp_mbox", 32'(last_rd), 32'h04);
    bus(16'hFE31, 1'b1, 8'h00);
    check("fe31_no_oe", 32'(oe_cnt), 32'd0);
    bus(16'h3000, 1'b0, 8'hAA);
    bus(MBOX, 1'b1, 8'h00);
    check("skip_mbox", 32'(last_rd), 32'h04);
    check("skip_romsel", 32'(romsel_q), 32'hF);
    rdy_mode = 1;
    tick(12);
    rdy_mode = 0;
    bus(ROMSEL, 1'b1, 8'h00, 1);
    check("abort_romsel", 32'(romsel_q), 32'h0);
    check("abort_valid", 32'(wlog_valid), 32'h0);
    check("abort_dout", 32'(bbc_data_out), 32'h00);
    bus(ROMSEL, 1'b0, 8'h0A, 1);
    tick(4);
    check("abort_wr", 32'(romsel_q), 32'h0);
    bus(16'h8000, 1'b1, 8'h00);
    bus(16'h8012, 1'b1, 8'h00);
    bus(16'h80FF, 1'b1, 8'h00);
    check("dummy3", 32'(dummy_cnt), 32'(EXP3));
    bus(16'h8000, 1'b0, 8'h11);
    check("dummy_wr", 32'(dummy_cnt), 32'(EXP3));
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: a = ROMSEL;
        1: a = MBOX;
        2: a = 16'hFE31;
        3: a = {8'hFE, 8'($urandom)};
        4: a = {8'h80, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      bus(a, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    rdy_mode = 1;
    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
